axis_frame_len_check: RTL

AXIS_FRAME_LEN_CHECK -- requirements
Module: axis_frame_len_check

---
 rtl/axis_frame_len_check.sv | 109 ++++++++++
 1 files changed

// File: rtl/axis_frame_len_check.sv
// axis_frame_len_check: AXI-Stream frame length policer that truncates oversize frames and marks them bad in tuser.
// Optional undersize check enabled by defining AXIS_FRAME_LEN_CHECK_UNDERSIZE_EN.
module axis_frame_len_check #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH = 16,
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_frame_valid,
  output logic                  status_oversize,
  output logic                  status_undersize
);
`ifdef AXIS_FRAME_LEN_CHECK_UNDERSIZE_EN
  localparam bit UNDER_EN = 1'b1;
`else
  localparam bit UNDER_EN = 1'b0;
`endif
  typedef enum logic {PASS, DROP} state_t;
  state_t state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, beat_bytes, sum_sat, len_q, len_d;
  logic [LEN_WIDTH:0] sum;
  logic over, under, accept, load, term;
  logic tvalid_q, tvalid_d, fv_q, fv_d, ov_q, ov_d, un_q, un_d, last_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic tlast_q;
  logic [USER_WIDTH-1:0] tuser_q, user_d;
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      beat_bytes = beat_bytes + LEN_WIDTH'(KEEP_ENABLE == 0 || s_axis_tkeep[i]);
    sum = {1'b0, cnt_q} + {1'b0, beat_bytes};
    sum_sat = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    over = sum > (LEN_WIDTH+1)'(MAX_LEN);
    under = UNDER_EN && s_axis_tlast && !over && sum < (LEN_WIDTH+1)'(MIN_LEN);
    s_axis_tready = state_q == DROP || m_axis_tready || !tvalid_q;
    accept = s_axis_tvalid && s_axis_tready;
    load = accept && state_q == PASS;
    // An oversize beat closes the frame on the output even when the input frame continues.
    term = load && (s_axis_tlast || over);
    state_d = state_q == PASS ? ((load && over && !s_axis_tlast) ? DROP : PASS)
                              : ((accept && s_axis_tlast) ? PASS : DROP);
    cnt_d = term ? '0 : (load ? sum_sat : cnt_q);
    tvalid_d = load ? 1'b1 : (m_axis_tready ? 1'b0 : tvalid_q);
    last_d = s_axis_tlast || over;
    user_d = (over || under) ? ((s_axis_tuser & ~USER_BAD_FRAME_MASK) |
                                (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK)) : s_axis_tuser;
    fv_d = term;
    ov_d = term && over;
    un_d = term && under;
    len_d = term ? sum_sat : len_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
      cnt_q <= '0;
      tvalid_q <= 1'b0;
      fv_q <= 1'b0;
      ov_q <= 1'b0;
      un_q <= 1'b0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tvalid_q <= tvalid_d;
      fv_q <= fv_d;
      ov_q <= ov_d;
      un_q <= un_d;
      len_q <= len_d;
    end
  end
  always_ff @(posedge clk) begin
    if (load) begin
      tdata_q <= s_axis_tdata;
      tkeep_q <= s_axis_tkeep;
      tlast_q <= last_d;
      tuser_q <= user_d;
    end
  end
  assign m_axis_tdata = tdata_q;
  assign m_axis_tkeep = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast = tlast_q;
  assign m_axis_tuser = tuser_q;
  assign status_frame_len = len_q;
  assign status_frame_valid = fv_q;
  assign status_oversize = ov_q;
  assign status_undersize = un_q;
endmodule
